// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: memory-mapped NUM_DIGITS seven-segment controller with
// hex/raw digit modes, per-digit blink, brightness PWM and optional scrolling.
// Optional feature macro: HEX_SCROLL_EN (hardware scrolling of digit content).
module hex_display_ctrl #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BLINK_HZ   = 2,
   parameter int unsigned SCROLL_DIV = 25000000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDR_W-1:0]       address,
   input  logic                    chipselect,
   input  logic                    write,
   input  logic                    read,
   input  logic [7:0]              writedata,
   output logic [7:0]              readdata,
   output logic [7*NUM_DIGITS-1:0] hex
);

   localparam int unsigned BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int unsigned OFF_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CTRL_ADDR  = NUM_DIGITS;
   localparam int unsigned MASK_ADDR  = NUM_DIGITS + 1;

   // Elaboration-time parameter sanity checks
   generate
      if (NUM_DIGITS < 1 || NUM_DIGITS > 14) begin : g_bad_digits
         $error("NUM_DIGITS must be in 1..14");
      end
      if (NUM_DIGITS + 2 > (1 << ADDR_W)) begin : g_bad_addr
         $error("ADDR_W too small for NUM_DIGITS+2 registers");
      end
      if (BLINK_HALF < 1) begin : g_bad_blink
         $error("CLK_HZ/(2*BLINK_HZ) must be at least 1");
      end
      if (SCROLL_DIV < 1) begin : g_bad_scroll
         $error("SCROLL_DIV must be at least 1");
      end
   endgenerate

   logic [7:0]            digit [NUM_DIGITS];
   logic [4:0]            ctrl;          // {BLINK_EN, BRIGHT[2:0], EN}
   logic                  scroll;
   logic [NUM_DIGITS-1:0] blink_mask;
   logic [BLINK_W-1:0]    blink_cnt;
   logic                  phase;
   logic [2:0]            pwm;
   logic [OFF_W-1:0]      offset;
   logic                  wr;
   logic                  ctrl_wr;
   logic [7:0]            rd_mux;
   logic [7*NUM_DIGITS-1:0] hex_next;

   assign wr      = chipselect & write;
   assign ctrl_wr = wr && (address == ADDR_W'(CTRL_ADDR));

   // Standard a..g hex decode, active-high, bit0 = segment a
   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Register file: digit, control and blink-mask registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
         ctrl       <= '0;
         blink_mask <= '0;
      end else if (wr) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            if (address == ADDR_W'(i)) digit[i] <= writedata;
         if (address == ADDR_W'(CTRL_ADDR)) ctrl <= writedata[4:0];
         if (address == ADDR_W'(MASK_ADDR)) blink_mask <= NUM_DIGITS'(writedata);
      end
   end

   // Read-data source selection; unmapped addresses read zero
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (address == ADDR_W'(i)) rd_mux = digit[i];
      if (address == ADDR_W'(CTRL_ADDR)) rd_mux = {2'b00, scroll, ctrl};
      if (address == ADDR_W'(MASK_ADDR)) rd_mux = 8'(blink_mask);
   end

   // Registered read data, held between reads (old value on read+write)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                readdata <= '0;
      else if (chipselect && read) readdata <= rd_mux;
   end

   // Blink prescaler and phase; phase parked visible while blink disabled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (!ctrl[4]) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + BLINK_W'(1);
      end
   end

   // Free-running brightness PWM counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pwm <= '0;
      else          pwm <= pwm + 3'd1;
   end

`ifdef HEX_SCROLL_EN
   localparam int unsigned SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   logic [SCROLL_W-1:0] scroll_cnt;

   // Scroll prescaler and rotation offset; a 0->1 SCROLL write restarts at 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scroll     <= 1'b0;
         scroll_cnt <= '0;
         offset     <= '0;
      end else begin
         if (ctrl_wr) scroll <= writedata[5];
         if (ctrl_wr && writedata[5] && !scroll) begin
            scroll_cnt <= '0;
            offset     <= '0;
         end else if (!scroll) begin
            scroll_cnt <= '0;
         end else if (scroll_cnt == SCROLL_W'(SCROLL_DIV - 1)) begin
            scroll_cnt <= '0;
            offset     <= (offset == OFF_W'(NUM_DIGITS - 1)) ? '0 : offset + OFF_W'(1);
         end else begin
            scroll_cnt <= scroll_cnt + SCROLL_W'(1);
         end
      end
   end
`else
   assign scroll = 1'b0;
   assign offset = '0;
`endif

   // Per-digit pattern selection, brightness and blink gating
   always_comb begin
      logic [OFF_W:0]   sum;
      logic [OFF_W-1:0] src;
      logic [6:0]       pat;
      logic             lit;
      hex_next = '1;
      sum      = '0;
      src      = '0;
      pat      = '0;
      lit      = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         sum = (OFF_W+1)'(i) + {1'b0, offset};
         if (sum >= (OFF_W+1)'(NUM_DIGITS)) sum = sum - (OFF_W+1)'(NUM_DIGITS);
         src = sum[OFF_W-1:0];
         pat = digit[src][7] ? digit[src][6:0] : seg_decode(digit[src][3:0]);
         lit = ctrl[0] & (pwm <= ctrl[3:1]) & ~(ctrl[4] & blink_mask[src] & ~phase);
         hex_next[7*i +: 7] = lit ? ~pat : 7'h7F;
      end
   end

   // Output register, active-low segments
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hex <= '1;
      else          hex <= hex_next;
   end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: randomized self-checking bench for hex_display_ctrl
// against a time-based behavioural model of the display.
`timescale 1ns/1ps
module tb_hex_display_ctrl;

   localparam int N          = 6;
   localparam int ADDR_W     = 4;
   localparam int CLK_HZ     = 16;
   localparam int BLINK_HZ   = 2;
   localparam int SCROLL_DIV = 4;
   localparam int H          = CLK_HZ / (2 * BLINK_HZ);
`ifdef HEX_SCROLL_EN
   localparam logic [7:0] CTRL_MASK = 8'h3F;
`else
   localparam logic [7:0] CTRL_MASK = 8'h1F;
`endif
   localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic              clk;
   logic              reset_n;
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write;
   logic              read;
   logic [7:0]        writedata;
   logic [7:0]        readdata;
   logic [7*N-1:0]    hex;

   hex_display_ctrl #(
      .NUM_DIGITS(N), .ADDR_W(ADDR_W), .CLK_HZ(CLK_HZ),
      .BLINK_HZ(BLINK_HZ), .SCROLL_DIV(SCROLL_DIV)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write(write), .read(read), .writedata(writedata), .readdata(readdata), .hex(hex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release: the edge just passed has index edges-1
   int edges;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) edges <= 0;
      else          edges <= edges + 1;
   end

   logic [7:0] m_digit [N];
   logic [7:0] m_ctrl, m_mask;
   int         blink_b, scroll_s, off_frozen;
   int         n_checks, n_pass;

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_digit[i] = 8'h00;
      m_ctrl = 8'h00; m_mask = 8'h00;
      blink_b = 0; scroll_s = 0; off_frozen = 0;
   endtask

   // Register write landing on edge w
   task automatic model_write(input int a, input logic [7:0] d, input int w);
      logic [7:0] nc;
      nc = d & CTRL_MASK;
      if (a < N) m_digit[a] = d;
      else if (a == N) begin
         if (nc[4] && !m_ctrl[4]) blink_b = w;
         if (nc[5] && !m_ctrl[5]) scroll_s = w;
         if (!nc[5] && m_ctrl[5]) off_frozen = ((w - scroll_s) / SCROLL_DIV) % N;
         m_ctrl = nc;
      end else if (a == N + 1) m_mask = d & 8'h3F;
   endtask

   function automatic int m_offset(input int e);
      if (m_ctrl[5]) return ((e - 1 - scroll_s) / SCROLL_DIV) % N;
      return off_frozen;
   endfunction

   function automatic logic m_phase(input int e);
      if (!m_ctrl[4]) return 1'b1;
      return (((e - 1 - blink_b) / H) % 2) == 0;
   endfunction

   // Expected hex produced on edge e
   function automatic logic [7*N-1:0] exp_hex(input int e);
      logic [7*N-1:0] r;
      logic [6:0]     pat;
      logic           lit;
      int             src;
      r = '1;
      for (int i = 0; i < N; i++) begin
         src = (i + m_offset(e)) % N;
         pat = m_digit[src][7] ? m_digit[src][6:0] : SEG[m_digit[src][3:0]];
         lit = m_ctrl[0] && ((e % 8) <= int'(m_ctrl[3:1])) && !(m_mask[src] && !m_phase(e));
         if (lit) r[7*i +: 7] = ~pat;
      end
      return r;
   endfunction

   function automatic logic [7:0] exp_read(input int a);
      if (a < N) return m_digit[a];
      if (a == N) return m_ctrl;
      if (a == N + 1) return m_mask;
      return 8'h00;
   endfunction

   task automatic bus_write(input int a, input logic [7:0] d);
      address = ADDR_W'(a); writedata = d; chipselect = 1'b1; write = 1'b1;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
      model_write(a, d, edges - 1);
   endtask

   task automatic bus_read(input int a, output logic [7:0] got);
      address = ADDR_W'(a); chipselect = 1'b1; read = 1'b1;
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
      got = readdata;
   endtask

   task automatic test_reset();
      logic [7:0] got;
      n_checks++;
      if (hex !== {7*N{1'b1}} || readdata !== 8'h00)
         $display("FAIL reset_values: hex=%h readdata=%h required all ones / 00", hex, readdata);
      else n_pass++;
      @(negedge clk) reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (hex !== 42'h3FFFFFFFFFF) $display("FAIL idle_hex: got %h required %h", hex, 42'h3FFFFFFFFFF);
         else n_pass++;
      end
      for (int a = 0; a < 16; a++) begin
         bus_read(a, got);
         n_checks++;
         if (got !== 8'h00) $display("FAIL reset_read addr %0d: got %h required 00", a, got);
         else n_pass++;
      end
   endtask

   task automatic test_decode();
      bus_write(0, 8'h00);
      bus_write(1, 8'h0A);
      bus_write(2, 8'h01);
      @(negedge clk);
      bus_write(N, 8'h0F);
      n_checks++;
      if (hex !== {7*N{1'b1}}) $display("FAIL decode_latency_early: got %h required all ones", hex);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (hex !== {7'h40, 7'h40, 7'h40, 7'h79, 7'h08, 7'h40})
         $display("FAIL decode_pattern: got %h required %h", hex, {7'h40, 7'h40, 7'h40, 7'h79, 7'h08, 7'h40});
      else n_pass++;
      n_checks++;
      if (hex !== exp_hex(edges - 1)) $display("FAIL decode_model: got %h required %h", hex, exp_hex(edges - 1));
      else n_pass++;
   endtask

   task automatic test_pwm();
      int lit_cnt;
      lit_cnt = 0;
      bus_write(N, 8'h07);
      repeat (24) begin
         @(negedge clk);
         n_checks++;
         if (hex !== exp_hex(edges - 1)) $display("FAIL pwm_hex: got %h required %h", hex, exp_hex(edges - 1));
         else n_pass++;
         if (hex[6:0] != 7'h7F) lit_cnt++;
      end
      n_checks++;
      if (lit_cnt != 12) $display("FAIL pwm_duty: lit %0d of 24 cycles, required 12", lit_cnt);
      else n_pass++;
   endtask

   task automatic test_blink();
      int lit0, lit1;
      lit0 = 0; lit1 = 0;
      bus_write(N + 1, 8'h01);
      bus_write(N, 8'h1F);
      repeat (16) begin
         @(negedge clk);
         n_checks++;
         if (hex !== exp_hex(edges - 1)) $display("FAIL blink_hex: got %h required %h", hex, exp_hex(edges - 1));
         else n_pass++;
         if (hex[6:0] != 7'h7F) lit0++;
         if (hex[13:7] != 7'h7F) lit1++;
      end
      n_checks++;
      if (lit0 != 8 || lit1 != 16) $display("FAIL blink_counts: digit0 lit %0d (req 8), digit1 lit %0d (req 16)", lit0, lit1);
      else n_pass++;
      bus_write(N, 8'h0F);
      repeat (6) begin
         @(negedge clk);
         n_checks++;
         if (hex[6:0] !== 7'h40) $display("FAIL blink_off_steady: digit0 got %h required 40", hex[6:0]);
         else n_pass++;
      end
      bus_write(N + 1, 8'h00);
   endtask

   task automatic test_raw_read();
      logic [7:0] got;
      bus_write(3, 8'hC9);
      @(negedge clk);
      n_checks++;
      if (hex[27:21] !== 7'h36) $display("FAIL raw_pattern: got %h required 36", hex[27:21]);
      else n_pass++;
      bus_read(3, got);
      n_checks++;
      if (got !== 8'hC9) $display("FAIL read_digit3: got %h required c9", got);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (readdata !== 8'hC9) $display("FAIL read_hold: got %h required c9", readdata);
      else n_pass++;
      bus_read(15, got);
      n_checks++;
      if (got !== 8'h00) $display("FAIL read_unmapped: got %h required 00", got);
      else n_pass++;
      // read and write the same register in one cycle
      address = 4'd3; writedata = 8'h05; chipselect = 1'b1; write = 1'b1; read = 1'b1;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0; read = 1'b0;
      n_checks++;
      if (readdata !== 8'hC9) $display("FAIL read_during_write: got %h required c9", readdata);
      else n_pass++;
      model_write(3, 8'h05, edges - 1);
      bus_read(3, got);
      n_checks++;
      if (got !== 8'h05) $display("FAIL read_after_write: got %h required 05", got);
      else n_pass++;
      bus_write(N + 1, 8'hFF);
      bus_read(N + 1, got);
      n_checks++;
      if (got !== 8'h3F) $display("FAIL read_blinkmask: got %h required 3f", got);
      else n_pass++;
      bus_write(N, 8'hFF);
      bus_read(N, got);
      n_checks++;
      if (got !== CTRL_MASK) $display("FAIL read_ctrl: got %h required %h", got, CTRL_MASK);
      else n_pass++;
      bus_write(N + 1, 8'h00);
      bus_write(N, 8'h0F);
   endtask

   task automatic test_random();
      logic [7:0] got, d;
      int a;
      for (int it = 0; it < 60; it++) begin
         a = $urandom_range(0, 15);
         d = 8'($urandom);
         if (a == N) d[0] = d[0] | ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) begin
            bus_read(a, got);
            n_checks++;
            if (got !== exp_read(a)) $display("FAIL rand_read addr %0d: got %h required %h", a, got, exp_read(a));
            else n_pass++;
         end else begin
            bus_write(a, d);
         end
         repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            n_checks++;
            if (hex !== exp_hex(edges - 1)) $display("FAIL rand_hex: got %h required %h", hex, exp_hex(edges - 1));
            else n_pass++;
         end
      end
      bus_write(N + 1, 8'h00);
      bus_write(N, 8'h0F);
   endtask

`ifdef HEX_SCROLL_EN
   task automatic test_scroll();
      for (int i = 0; i < N; i++) bus_write(i, 8'(i));
      bus_write(N, 8'h2F);
      repeat (4) @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (hex[6:0] !== 7'h79) $display("FAIL scroll_step: digit0 got %h required 79", hex[6:0]);
      else n_pass++;
      repeat (30) begin
         @(negedge clk);
         n_checks++;
         if (hex !== exp_hex(edges - 1)) $display("FAIL scroll_hex: got %h required %h", hex, exp_hex(edges - 1));
         else n_pass++;
      end
      bus_write(N, 8'h0F);
      repeat (8) begin
         @(negedge clk);
         n_checks++;
         if (hex !== exp_hex(edges - 1)) $display("FAIL scroll_frozen: got %h required %h", hex, exp_hex(edges - 1));
         else n_pass++;
      end
      bus_write(N, 8'h2F);
      repeat (3) @(negedge clk);
   endtask
`endif

   task automatic test_async_reset();
      logic [7:0] got;
      bus_write(0, 8'h08);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (hex !== {7*N{1'b1}} || readdata !== 8'h00)
         $display("FAIL async_reset: hex=%h readdata=%h required all ones / 00", hex, readdata);
      else n_pass++;
      model_reset();
      @(negedge clk) reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (hex !== {7*N{1'b1}}) $display("FAIL post_reset_hex: got %h required all ones", hex);
         else n_pass++;
      end
      bus_read(N, got);
      n_checks++;
      if (got !== 8'h00) $display("FAIL post_reset_ctrl: got %h required 00", got);
      else n_pass++;
      bus_write(N, 8'h0F);
      @(negedge clk);
      n_checks++;
      if (hex !== {N{7'h40}}) $display("FAIL post_reset_digits: got %h required all 40", hex);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      reset_n = 1'b0; address = '0; chipselect = 1'b0; write = 1'b0; read = 1'b0; writedata = '0;
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      test_decode();
      test_pwm();
      test_blink();
      test_raw_read();
      test_random();
`ifdef HEX_SCROLL_EN
      test_scroll();
`endif
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
